// File: rtl/camera_line_buffer_pkg.sv
// Shared constants and width helpers for the camera line buffer.
// Widths derived here are used by both the position tracker and the buffer top.
package camera_line_buffer_pkg;

  localparam int PIX_DATA_W = 10;

  // Address width for a range of 'value' entries, never below one bit.
  function automatic int clog2(input int value);
    int width;
    width = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 <<< i) < value) begin
        width = i + 1;
      end else begin
        width = width;
      end
    end
    return (width < 1) ? 1 : width;
  endfunction

endpackage

// File: rtl/camera_line_buffer_tracker.sv
// Frame/line/column position tracker for a parallel sensor interface.
// Arms on the first idle frame strobe and emits registered, in-range pixels.
module cam_pos_tracker
  import camera_line_buffer_pkg::*;
#(
  parameter int LINES   = 3,
  parameter int COLUMNS = 2,
  parameter int DATA_W  = PIX_DATA_W,
  parameter int LW      = clog2(LINES),
  parameter int CW      = clog2(COLUMNS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              frame_valid,
  input  logic              line_valid,
  input  logic [DATA_W-1:0] data_in,
  output logic              pixel_valid,
  output logic [DATA_W-1:0] pixel_data,
  output logic [LW-1:0]     current_line,
  output logic [CW-1:0]     current_column
);

  // Counters are one value wider than the index range so they can park at LINES/COLUMNS.
  localparam int LCW = clog2(LINES + 1);
  localparam int CCW = clog2(COLUMNS + 1);
  localparam logic [LCW-1:0] LINES_C   = LCW'(LINES);
  localparam logic [CCW-1:0] COLUMNS_C = CCW'(COLUMNS);

  logic              armed_r;
  logic              lv_prev_r;
  logic [LCW-1:0]    line_cnt_r;
  logic [CCW-1:0]    col_cnt_r;
  logic              pixel_valid_r;
  logic [DATA_W-1:0] pixel_data_r;
  logic [LW-1:0]     cur_line_r;
  logic [CW-1:0]     cur_col_r;

  // Arming, line-strobe edge detection, saturating counters and pixel output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed_r       <= 1'b0;
      lv_prev_r     <= 1'b0;
      line_cnt_r    <= '0;
      col_cnt_r     <= '0;
      pixel_valid_r <= 1'b0;
      pixel_data_r  <= '0;
      cur_line_r    <= '0;
      cur_col_r     <= '0;
    end else begin
      lv_prev_r     <= line_valid;
      pixel_valid_r <= 1'b0;
      if (!frame_valid) begin
        armed_r    <= 1'b1;
        line_cnt_r <= '0;
        col_cnt_r  <= '0;
      end else if (armed_r) begin
        if (line_valid) begin
          if ((line_cnt_r < LINES_C) && (col_cnt_r < COLUMNS_C)) begin
            pixel_valid_r <= 1'b1;
            pixel_data_r  <= data_in;
            cur_line_r    <= line_cnt_r[LW-1:0];
            cur_col_r     <= col_cnt_r[CW-1:0];
          end
          if (col_cnt_r < COLUMNS_C) begin
            col_cnt_r <= col_cnt_r + CCW'(1);
          end
        end else if (lv_prev_r) begin
          if (line_cnt_r < LINES_C) begin
            line_cnt_r <= line_cnt_r + LCW'(1);
          end
          col_cnt_r <= '0;
        end
      end
    end
  end

  assign pixel_valid    = pixel_valid_r;
  assign pixel_data     = pixel_data_r;
  assign current_line   = cur_line_r;
  assign current_column = cur_col_r;

endmodule

// File: rtl/camera_line_buffer.sv
// Single-line capture buffer behind the sensor position tracker.
// Holds the selected line stable until the consumer acknowledges it.
module camera_line_buffer
  import camera_line_buffer_pkg::*;
#(
  parameter int LINES   = 3,
  parameter int COLUMNS = 2,
  parameter int DATA_W  = PIX_DATA_W,
  parameter int LW      = clog2(LINES),
  parameter int CW      = clog2(COLUMNS)
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              FRAME_VALID,
  input  logic              LINE_VALID,
  input  logic [DATA_W-1:0] DATA_IN,
  input  logic [LW-1:0]     INTERESTING_LINE,
  input  logic [CW-1:0]     READ_ADDRESS,
  input  logic              RESET_READY_FLAG,
  output logic              WHOLE_LINE_READY_FLAG,
  output logic [DATA_W-1:0] DATA_OUT,
  output logic              PIXEL_VALID,
  output logic [LW-1:0]     CURRENT_LINE,
  output logic [CW-1:0]     CURRENT_COLUMN
);

  localparam logic [CW:0]   COLS_C     = (CW + 1)'(COLUMNS);
  localparam logic [CW-1:0] LAST_COL_C = CW'(COLUMNS - 1);

  logic              cam_valid_s;
  logic [DATA_W-1:0] cam_data_s;
  logic [LW-1:0]     cam_line_s;
  logic [CW-1:0]     cam_col_s;
  logic              we_s;
  logic              set_s;
  logic [DATA_W-1:0] rd_data_s;
  logic              flag_r;
  logic [DATA_W-1:0] data_out_r;
  logic [DATA_W-1:0] mem_r [COLUMNS];

  cam_pos_tracker #(
    .LINES   (LINES),
    .COLUMNS (COLUMNS),
    .DATA_W  (DATA_W),
    .LW      (LW),
    .CW      (CW)
  ) u_tracker (
    .clk            (CLK),
    .rst_n          (RESET_N),
    .frame_valid    (FRAME_VALID),
    .line_valid     (LINE_VALID),
    .data_in        (DATA_IN),
    .pixel_valid    (cam_valid_s),
    .pixel_data     (cam_data_s),
    .current_line   (cam_line_s),
    .current_column (cam_col_s)
  );

  // Write enable, flag set condition and range-guarded read mux.
  always_comb begin
    we_s      = cam_valid_s && (cam_line_s == INTERESTING_LINE) && !flag_r;
    set_s     = we_s && (cam_col_s == LAST_COL_C);
    rd_data_s = '0;
    if ({1'b0, READ_ADDRESS} < COLS_C) begin
      rd_data_s = mem_r[READ_ADDRESS];
    end else begin
      rd_data_s = '0;
    end
  end

  // Line RAM write port; contents deliberately not reset.
  always_ff @(posedge CLK) begin
    if (we_s) begin
      mem_r[cam_col_s] <= cam_data_s;
    end
  end

  // Ready flag (acknowledge beats set) and registered read data.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      flag_r     <= 1'b0;
      data_out_r <= '0;
    end else begin
      data_out_r <= rd_data_s;
      if (RESET_READY_FLAG) begin
        flag_r <= 1'b0;
      end else if (set_s) begin
        flag_r <= 1'b1;
      end
    end
  end

  assign WHOLE_LINE_READY_FLAG = flag_r;
  assign DATA_OUT              = data_out_r;
  assign PIXEL_VALID           = cam_valid_s;
  assign CURRENT_LINE          = cam_line_s;
  assign CURRENT_COLUMN        = cam_col_s;

endmodule

// File: tb/tb_camera_line_buffer.sv
// Directed bench for camera_line_buffer with a frame-level reference model.
// The model counts lines/pixels with plain integers and tracks the buffer as an array.
module tb_camera_line_buffer;

  localparam int LINES   = 3;
  localparam int COLUMNS = 2;
  localparam int DATA_W  = 10;
  localparam int LW      = 2;
  localparam int CW      = 1;

  logic              CLK = 1'b0;
  logic              RESET_N;
  logic              FRAME_VALID;
  logic              LINE_VALID;
  logic [DATA_W-1:0] DATA_IN;
  logic [LW-1:0]     INTERESTING_LINE;
  logic [CW-1:0]     READ_ADDRESS;
  logic              RESET_READY_FLAG;
  logic              WHOLE_LINE_READY_FLAG;
  logic [DATA_W-1:0] DATA_OUT;
  logic              PIXEL_VALID;
  logic [LW-1:0]     CURRENT_LINE;
  logic [CW-1:0]     CURRENT_COLUMN;

  int checks = 0;
  int errors = 0;

  camera_line_buffer #(.LINES(LINES), .COLUMNS(COLUMNS), .DATA_W(DATA_W)) dut (
    .CLK                   (CLK),
    .RESET_N               (RESET_N),
    .FRAME_VALID           (FRAME_VALID),
    .LINE_VALID            (LINE_VALID),
    .DATA_IN               (DATA_IN),
    .INTERESTING_LINE      (INTERESTING_LINE),
    .READ_ADDRESS          (READ_ADDRESS),
    .RESET_READY_FLAG      (RESET_READY_FLAG),
    .WHOLE_LINE_READY_FLAG (WHOLE_LINE_READY_FLAG),
    .DATA_OUT              (DATA_OUT),
    .PIXEL_VALID           (PIXEL_VALID),
    .CURRENT_LINE          (CURRENT_LINE),
    .CURRENT_COLUMN        (CURRENT_COLUMN)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: integer line/pixel counts since frame start, plus a shadow line store.
  bit armed = 1'b0, lv_prev = 1'b0;
  int lines_done = 0, pix = 0;
  bit m_pv = 1'b0, m_flag = 1'b0, m_dout_ok = 1'b1;
  int m_line = 0, m_col = 0, m_data = 0, m_dout = 0;
  int m_mem [COLUMNS];
  bit m_known [COLUMNS] = '{default: 1'b0};

  always @(posedge CLK) begin
    bit wr;
    bit emit;
    if (RESET_N !== 1'b1) begin
      armed = 0; lv_prev = 0; lines_done = 0; pix = 0;
      m_pv = 0; m_flag = 0; m_line = 0; m_col = 0; m_data = 0;
      m_dout = 0; m_dout_ok = 1;
    end else begin
      m_dout_ok = m_known[READ_ADDRESS];
      m_dout    = m_mem[READ_ADDRESS];
      wr = m_pv && (m_line == int'(INTERESTING_LINE)) && !m_flag;
      if (RESET_READY_FLAG) m_flag = 0;
      else if (wr && m_col == COLUMNS - 1) m_flag = 1;
      if (wr) begin
        m_mem[m_col] = m_data;
        m_known[m_col] = 1;
      end
      emit = 0;
      if (!FRAME_VALID) begin
        armed = 1; lines_done = 0; pix = 0;
      end else if (armed) begin
        if (LINE_VALID) begin
          if (lines_done < LINES && pix < COLUMNS) begin
            emit = 1; m_line = lines_done; m_col = pix; m_data = int'(DATA_IN);
          end
          pix++;
        end else if (lv_prev) begin
          lines_done++; pix = 0;
        end
      end
      lv_prev = LINE_VALID;
      m_pv = emit;
    end
  end

  // Per-cycle comparison against the model on the falling edge.
  always @(negedge CLK) begin
    if (RESET_N === 1'b1) begin
      chk("pixel_valid", 32'(PIXEL_VALID), 32'(m_pv));
      chk("ready_flag", 32'(WHOLE_LINE_READY_FLAG), 32'(m_flag));
      chk("current_line", 32'(CURRENT_LINE), 32'(m_line));
      chk("current_column", 32'(CURRENT_COLUMN), 32'(m_col));
      if (m_dout_ok) chk("data_out", 32'(DATA_OUT), 32'(m_dout));
    end
  end

  task automatic step(input logic fv, input logic lv, input int d);
    FRAME_VALID = fv;
    LINE_VALID  = lv;
    DATA_IN     = DATA_W'(d);
    @(posedge CLK);
    #1;
  endtask

  task automatic send_line(input int n, input int base);
    for (int i = 0; i < n; i++) step(1'b1, 1'b1, base + i + 1);
    step(1'b1, 1'b0, 0);
  endtask

  task automatic frame3(input int n0, input int b0, input int n1, input int b1,
                        input int n2, input int b2);
    step(1'b0, 1'b0, 0);
    step(1'b1, 1'b0, 0);
    send_line(n0, b0);
    send_line(n1, b1);
    send_line(n2, b2);
    step(1'b0, 1'b0, 0);
  endtask

  task automatic read_chk(input int addr, input int exp);
    READ_ADDRESS = CW'(addr);
    step(1'b0, 1'b0, 0);
    chk("read_literal", 32'(DATA_OUT), 32'(exp));
  endtask

  task automatic ack();
    RESET_READY_FLAG = 1'b1;
    step(1'b0, 1'b0, 0);
    RESET_READY_FLAG = 1'b0;
    chk("ack_clears_flag", 32'(WHOLE_LINE_READY_FLAG), 32'd0);
  endtask

  initial begin
    RESET_N = 1'b0; FRAME_VALID = 1'b1; LINE_VALID = 1'b1; DATA_IN = 10'd5;
    INTERESTING_LINE = 2'd1; READ_ADDRESS = 1'b0; RESET_READY_FLAG = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    chk("reset_pixel_valid", 32'(PIXEL_VALID), 32'd0);
    chk("reset_flag", 32'(WHOLE_LINE_READY_FLAG), 32'd0);
    chk("reset_data_out", 32'(DATA_OUT), 32'd0);
    chk("reset_line_col", 32'({CURRENT_LINE, CURRENT_COLUMN}), 32'd0);

    // Reset released mid-frame: nothing may be emitted until FV has dropped.
    RESET_N = 1'b1;
    repeat (4) step(1'b1, 1'b1, 5);
    chk("midframe_no_pixel", 32'(PIXEL_VALID), 32'd0);
    step(1'b1, 1'b0, 0);
    step(1'b1, 1'b1, 5);
    step(1'b1, 1'b1, 5);
    chk("midframe_still_unarmed", 32'(PIXEL_VALID), 32'd0);
    chk("midframe_no_flag", 32'(WHOLE_LINE_READY_FLAG), 32'd0);

    // First capture with explicit flag timing around pixel 22.
    step(1'b0, 1'b0, 0);
    step(1'b1, 1'b0, 0);
    send_line(2, 10);
    step(1'b1, 1'b1, 21);
    step(1'b1, 1'b1, 22);
    chk("flag_low_at_last_pixel", 32'(WHOLE_LINE_READY_FLAG), 32'd0);
    step(1'b1, 1'b0, 0);
    chk("flag_high_two_edges", 32'(WHOLE_LINE_READY_FLAG), 32'd1);
    send_line(2, 30);
    step(1'b0, 1'b0, 0);
    read_chk(0, 21);
    read_chk(1, 22);

    // Hold: a new frame must not disturb the captured line.
    frame3(2, 80, 2, 90, 2, 70);
    chk("hold_flag", 32'(WHOLE_LINE_READY_FLAG), 32'd1);
    read_chk(0, 21);
    read_chk(1, 22);

    // Acknowledge then recapture.
    ack();
    frame3(2, 40, 2, 50, 2, 60);
    chk("recapture_flag", 32'(WHOLE_LINE_READY_FLAG), 32'd1);
    read_chk(0, 51);
    read_chk(1, 52);

    // Overlong lines and a fourth line.
    ack();
    step(1'b0, 1'b0, 0);
    step(1'b1, 1'b0, 0);
    send_line(3, 0);
    send_line(3, 3);
    send_line(2, 6);
    step(1'b1, 1'b1, 9);
    chk("fourth_line_dropped", 32'(PIXEL_VALID), 32'd0);
    step(1'b1, 1'b1, 10);
    step(1'b1, 1'b0, 0);
    step(1'b0, 1'b0, 0);
    read_chk(0, 4);
    read_chk(1, 5);

    // Short line 1: flag stays low, only column 0 changes.
    ack();
    frame3(2, 10, 1, 76, 2, 20);
    chk("short_line_no_flag", 32'(WHOLE_LINE_READY_FLAG), 32'd0);
    read_chk(0, 77);
    read_chk(1, 5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
